bumpy_motion: RTL and testbench
===============================

# bumpy_motion

Frame-rate motion engine for the Bumpy sprite. Once per video frame it moves the sprite through a bounce cycle: rise, fall, then land. It applies left/right steering and resolves tile collisions using the neighbour tile types supplied by `step_controller`. It drives `bumpy_x`/`bumpy_y` back into `step_controller` and the sprite renderer, and emits one-clock event pulses (brick hit, coin, teleport, gate, death) to the game-control logic.

## Interface
Parameters:
- `NUM_OF_ROWS`, 7: grid rows; tile size fixed at 64 px.
- `NUM_OF_COLS`, 10: grid columns.
- `START_X`, 0: reset/restart x in px; must be a multiple of 64.
- `START_Y`, 64: reset/restart y in px; must be a multiple of 64.
- `V_STEP`, 4: vertical px per frame; must divide 64.
- `H_STEP`, 4: horizontal px per frame; must divide 64.
- `BOUNCE_FRAMES`, 8: frames per rise phase (rise height = `V_STEP*BOUNCE_FRAMES`, must be < 64).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-clock pulse per frame; all motion happens only on it.
- `restart` in 1: one-clock pulse; leaves `DEAD`/`DONE` and reloads the start position.
- `leftKey`, `rightKey` in 1: level-sensitive steering.
- `area` in [3:0][2:0]: tile types around the tile holding the sprite centre (`bumpy_x+32`, `bumpy_y+32`). Index 0 is left, 1 is up, 2 is right, 3 is down.
- `teleport_cordinates` in 8: target of the tile below, as [7:4] column and [3:0] row.
- `bumpy_x`, `bumpy_y` out 11: sprite top-left position in px.
- `brick_hit`, `coin_hit`, `teleport`, `gate_reached`, `death` out 1: one-clock event pulses.
- `event_col` out 4, `event_row` out 3: tile that caused the last pulse.
- `state` out 3: current FSM state, for debug.

Tile codes: FREE=0, REGU=1, GATE=2, COIN=3, PORT=4, SPIK=5, BRAK=6. A tile is "passable" if it is FREE or COIN; every other code is solid.

## Operation
States: `IDLE`=0, `RISE`=1, `FALL`=2, `DEAD`=3, `DONE`=4.
- **Reset:** `IDLE`; `bumpy_x=START_X`, `bumpy_y=START_Y`; all pulses 0; `event_col`/`event_row`=0; rise counter 0.
- **IDLE:** the first `startOfFrame` moves to `FALL` without changing position.
- **RISE:** on each `startOfFrame`:
  - If `area[1]` is passable, `y -= V_STEP`; otherwise y is held.
  - The counter increments. When it reaches `BOUNCE_FRAMES`, clear it and go to `FALL`.
- **FALL, y not aligned** (`y[5:0]!=0`): `y += V_STEP`.
- **FALL, y aligned:** evaluate the landing from `area[3]`, with the event tile at (`x_centre>>6`, `(y>>6)+1`):
  - Row `y>>6` = `NUM_OF_ROWS-1` (no tile below): `death`, go to `DEAD`.
  - FREE: `y += V_STEP`.
  - REGU: go to `RISE`.
  - BRAK: pulse `brick_hit`, go to `RISE`.
  - COIN: pulse `coin_hit`, go to `RISE`.
  - SPIK: pulse `death`, go to `DEAD`.
  - GATE: pulse `gate_reached`, go to `DONE`.
  - PORT: pulse `teleport`; set `x = cordinates[7:4]*64` and `y = (cordinates[3:0]-1)*64` (use 0 if the row is 0); go to `RISE`.
- **Steering:** in `RISE`/`FALL` frames that are not landing frames, with exactly one key held, move by `H_STEP` in that direction. Movement is blocked when `x[5:0]==0` and either:
  - the side tile (`area[0]` or `area[2]`) is solid, or
  - x is at a bound (0 on the left, `(NUM_OF_COLS-1)*64` on the right).
- Both keys held or neither held: no horizontal move.
- **DEAD/DONE:** position frozen; `startOfFrame` and keys are ignored. `restart` reloads the start position and enters `IDLE`.
- **Priority:** `reset` > `restart` > `startOfFrame`.

## Timing
- Inputs are sampled on the `clk` edge where `startOfFrame`=1. Position, state and pulses update on that same edge, so they are visible in the next cycle.
- `area` and `teleport_cordinates` must be stable during the `startOfFrame` cycle. Since position only changes once per frame, the `step_controller` latency (at most 2 clocks) is absorbed.
- Each pulse lasts exactly one clock; at most one pulse fires per frame. `event_col`/`event_row` update with the pulse and hold until the next pulse.
- `reset` asserted mid-bounce, including in the same cycle as `startOfFrame`, restores all reset values on that edge.
- x and y never leave [0, `(NUM_OF_COLS-1)*64`] and [0, `(NUM_OF_ROWS-1)*64`].

## Test plan
- **Brick landing:** reset, then a `startOfFrame` with `area[3]`=BRAK → no pulse and state `FALL`. Next SOF → `brick_hit` with col 0, row 2, state `RISE`. After 8 SOF `bumpy_y`=32; after 8 more `bumpy_y`=64, landing evaluated again.
- **Spike landing:** aligned `FALL` with `area[3]`=SPIK → `death` for 1 clock, state `DEAD`. Ten further SOF with `rightKey` held leave x and y unchanged. `restart` → x=0, y=64, state `IDLE`.
- **Steering:** x=0, rising, `rightKey` held:
  - `area[2]`=REGU → x stays 0.
  - `area[2]`=FREE → x=4 after one SOF.
  - Both keys held → x unchanged.
- **Teleport:** aligned `FALL` with `area[3]`=PORT and `teleport_cordinates`=8'b0111_0110 → `teleport` pulse, x=448, y=320, state `RISE`.
- **Fall off grid:** y=384, aligned, `area[3]`=FREE → `death`, state `DEAD`.
- **Reset priority:** `reset` and `startOfFrame` asserted together mid-`RISE` → next cycle x=`START_X`, y=`START_Y`, state `IDLE`, no pulses.

Source files
------------

// File: rtl/bumpy_motion.sv
// -----------------------------------------------------------------------------
// bumpy_motion
//
// Frame-rate motion engine for the Bumpy sprite. Once per startOfFrame the
// sprite moves through a bounce cycle (rise, fall, land). Left/right steering
// is applied, and tile collisions are resolved from the neighbour tile types
// supplied by step_controller. Landing events are reported as one-clock pulses.
//
// Ports:
//   clk                  system clock
//   reset                synchronous, active-high reset
//   startOfFrame         one-clock pulse per video frame; all motion happens on it
//   restart              one-clock pulse; reload start position, enter IDLE
//   leftKey, rightKey    level-sensitive steering
//   area[3:0][2:0]       neighbour tiles of the centre tile: 0=left 1=up 2=right 3=down
//   teleport_cordinates  target of the tile below: [7:4] column, [3:0] row
//   bumpy_x, bumpy_y     sprite top-left position in px
//   brick_hit, coin_hit, teleport, gate_reached, death   one-clock event pulses
//   event_col, event_row tile that caused the last pulse
//   state                current FSM state (debug)
// -----------------------------------------------------------------------------
module bumpy_motion #(
    parameter int NUM_OF_ROWS   = 7,
    parameter int NUM_OF_COLS   = 10,
    parameter int START_X       = 0,
    parameter int START_Y       = 64,
    parameter int V_STEP        = 4,
    parameter int H_STEP        = 4,
    parameter int BOUNCE_FRAMES = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            startOfFrame,
    input  logic            restart,
    input  logic            leftKey,
    input  logic            rightKey,
    input  logic [3:0][2:0] area,
    input  logic [7:0]      teleport_cordinates,
    output logic [10:0]     bumpy_x,
    output logic [10:0]     bumpy_y,
    output logic            brick_hit,
    output logic            coin_hit,
    output logic            teleport,
    output logic            gate_reached,
    output logic            death,
    output logic [3:0]      event_col,
    output logic [2:0]      event_row,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RISE = 3'd1,
        S_FALL = 3'd2,
        S_DEAD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] TILE_FREE = 3'd0;
    localparam logic [2:0] TILE_REGU = 3'd1;
    localparam logic [2:0] TILE_GATE = 3'd2;
    localparam logic [2:0] TILE_COIN = 3'd3;
    localparam logic [2:0] TILE_PORT = 3'd4;
    localparam logic [2:0] TILE_SPIK = 3'd5;
    localparam logic [2:0] TILE_BRAK = 3'd6;

    localparam int CW = $clog2(BOUNCE_FRAMES + 1);

    localparam logic [10:0]   START_X_PX = 11'(START_X);
    localparam logic [10:0]   START_Y_PX = 11'(START_Y);
    localparam logic [10:0]   V_STEP_PX  = 11'(V_STEP);
    localparam logic [10:0]   H_STEP_PX  = 11'(H_STEP);
    localparam logic [10:0]   X_MAX      = 11'((NUM_OF_COLS - 1) * 64);
    localparam logic [4:0]    LAST_ROW   = 5'(NUM_OF_ROWS - 1);
    localparam logic [CW-1:0] RISE_LAST  = CW'(BOUNCE_FRAMES - 1);

    // Pulse vector bit positions
    localparam int P_BRICK = 0;
    localparam int P_COIN  = 1;
    localparam int P_PORT  = 2;
    localparam int P_GATE  = 3;
    localparam int P_DEATH = 4;

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    pulse_q, pulse_d;
    logic [3:0]    event_col_q, event_col_d;
    logic [2:0]    event_row_q, event_row_d;

    // Passability of the left, up and right neighbours
    logic [2:0] pass;
    for (genvar gi = 0; gi < 3; gi++) begin : g_pass
        assign pass[gi] = (area[gi] == TILE_FREE) || (area[gi] == TILE_COIN);
    end

    // Landing event tile: column of the sprite centre, row just below
    logic [3:0] land_col;
    logic [2:0] land_row;
    logic [3:0] port_row_m1;
    assign land_col    = 4'((x_q + 11'd32) >> 6);
    assign land_row    = 3'(y_q[10:6] + 5'd1);
    assign port_row_m1 = teleport_cordinates[3:0] - 4'd1;

    logic steer_en;
    logic left_blocked;
    logic right_blocked;

    // Horizontal motion is only constrained when x sits on a tile boundary;
    // between boundaries the sprite always completes the step it started.
    assign left_blocked  = (x_q[5:0] == 6'd0) && (!pass[0] || (x_q == 11'd0));
    assign right_blocked = (x_q[5:0] == 6'd0) && (!pass[2] || (x_q == X_MAX));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        pulse_d     = '0;
        event_col_d = event_col_q;
        event_row_d = event_row_q;
        steer_en    = 1'b0;

        if (restart) begin
            state_d = S_IDLE;
            x_d     = START_X_PX;
            y_d     = START_Y_PX;
            cnt_d   = '0;
        end else if (startOfFrame) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FALL;
                end
                S_RISE: begin
                    steer_en = 1'b1;
                    // The y guard keeps the sprite on-grid even if the
                    // tile above row 0 is reported passable.
                    if (pass[1] && (y_q >= V_STEP_PX)) begin
                        y_d = y_q - V_STEP_PX;
                    end
                    if (cnt_q == RISE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FALL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FALL: begin
                    if (y_q[5:0] != 6'd0) begin
                        y_d      = y_q + V_STEP_PX;
                        steer_en = 1'b1;
                    end else if (y_q[10:6] == LAST_ROW) begin
                        pulse_d[P_DEATH] = 1'b1;
                        event_col_d      = land_col;
                        event_row_d      = land_row;
                        state_d          = S_DEAD;
                    end else begin
                        unique case (area[3])
                            TILE_FREE: begin
                                y_d = y_q + V_STEP_PX;
                            end
                            TILE_BRAK: begin
                                pulse_d[P_BRICK] = 1'b1;
                                event_col_d      = land_col;
                                event_row_d      = land_row;
                                state_d          = S_RISE;
                            end
                            TILE_COIN: begin
                                pulse_d[P_COIN] = 1'b1;
                                event_col_d     = land_col;
                                event_row_d     = land_row;
                                state_d         = S_RISE;
                            end
                            TILE_SPIK: begin
                                pulse_d[P_DEATH] = 1'b1;
                                event_col_d      = land_col;
                                event_row_d      = land_row;
                                state_d          = S_DEAD;
                            end
                            TILE_GATE: begin
                                pulse_d[P_GATE] = 1'b1;
                                event_col_d     = land_col;
                                event_row_d     = land_row;
                                state_d         = S_DONE;
                            end
                            TILE_PORT: begin
                                pulse_d[P_PORT] = 1'b1;
                                event_col_d     = land_col;
                                event_row_d     = land_row;
                                x_d             = {1'b0, teleport_cordinates[7:4], 6'd0};
                                // Arrive one tile above the target row so the
                                // next bounce lands on it.
                                if (teleport_cordinates[3:0] == 4'd0) begin
                                    y_d = 11'd0;
                                end else begin
                                    y_d = {1'b0, port_row_m1, 6'd0};
                                end
                                state_d = S_RISE;
                            end
                            default: begin
                                // REGU and any unknown code: plain bounce
                                state_d = S_RISE;
                            end
                        endcase
                    end
                end
                default: begin
                    // DEAD / DONE: frozen until restart
                end
            endcase

            if (steer_en) begin
                if (leftKey && !rightKey && !left_blocked) begin
                    x_d = x_q - H_STEP_PX;
                end else if (rightKey && !leftKey && !right_blocked) begin
                    x_d = x_q + H_STEP_PX;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= START_X_PX;
            y_q         <= START_Y_PX;
            cnt_q       <= '0;
            pulse_q     <= '0;
            event_col_q <= '0;
            event_row_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            event_col_q <= event_col_d;
            event_row_q <= event_row_d;
        end
    end

    assign bumpy_x      = x_q;
    assign bumpy_y      = y_q;
    assign brick_hit    = pulse_q[P_BRICK];
    assign coin_hit     = pulse_q[P_COIN];
    assign teleport     = pulse_q[P_PORT];
    assign gate_reached = pulse_q[P_GATE];
    assign death        = pulse_q[P_DEATH];
    assign event_col    = event_col_q;
    assign event_row    = event_row_q;
    assign state        = state_q;

endmodule

// File: tb/tb_bumpy_motion.sv
module tb_bumpy_motion;

    localparam int ROWS = 7;
    localparam int COLS = 10;
    localparam int SX   = 0;
    localparam int SY   = 64;
    localparam int VS   = 4;
    localparam int HS   = 4;
    localparam int BF   = 8;

    localparam int FREE = 0, REGU = 1, GATE = 2, COIN = 3, PORT = 4, SPIK = 5, BRAK = 6;
    localparam int ST_IDLE = 0, ST_RISE = 1, ST_FALL = 2, ST_DEAD = 3, ST_DONE = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            sof = 1'b0;
    logic            restart = 1'b0;
    logic            lk = 1'b0;
    logic            rk = 1'b0;
    logic [3:0][2:0] area = '0;
    logic [7:0]      tc = '0;
    logic [10:0]     bumpy_x, bumpy_y;
    logic            brick_hit, coin_hit, teleport, gate_reached, death;
    logic [3:0]      event_col;
    logic [2:0]      event_row;
    logic [2:0]      state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int       m_state, m_x, m_y, m_cnt, m_col, m_row;
    logic [4:0] m_pulse;   // {death, gate, teleport, coin, brick}

    bumpy_motion dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (sof),
        .restart             (restart),
        .leftKey             (lk),
        .rightKey            (rk),
        .area                (area),
        .teleport_cordinates (tc),
        .bumpy_x             (bumpy_x),
        .bumpy_y             (bumpy_y),
        .brick_hit           (brick_hit),
        .coin_hit            (coin_hit),
        .teleport            (teleport),
        .gate_reached        (gate_reached),
        .death               (death),
        .event_col           (event_col),
        .event_row           (event_row),
        .state               (state)
    );

    always #5 clk = ~clk;

    function automatic bit passable(input int t);
        return (t == FREE) || (t == COIN);
    endfunction

    function automatic logic [4:0] dut_pulses();
        return {death, gate_reached, teleport, coin_hit, brick_hit};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_x = SX; m_y = SY; m_cnt = 0;
        m_pulse = '0; m_col = 0; m_row = 0;
    endtask

    // One frame of motion, computed from the bounce rules with plain arithmetic
    task automatic model_frame();
        bit steer;
        int row, below, ecol, erow;
        steer   = 0;
        m_pulse = '0;
        row     = m_y / 64;
        ecol    = (m_x + 32) / 64;
        erow    = (row + 1) % 8;
        below   = int'(area[3]);
        if (m_state == ST_IDLE) begin
            m_state = ST_FALL;
        end else if (m_state == ST_RISE) begin
            steer = 1;
            if (passable(int'(area[1])) && m_y >= VS) m_y -= VS;
            m_cnt++;
            if (m_cnt == BF) begin m_cnt = 0; m_state = ST_FALL; end
        end else if (m_state == ST_FALL) begin
            if (m_y % 64 != 0) begin
                m_y += VS;
                steer = 1;
            end else if (row == ROWS - 1 || below == SPIK) begin
                m_pulse[4] = 1; m_state = ST_DEAD; m_col = ecol; m_row = erow;
            end else if (below == FREE) begin
                m_y += VS;
            end else if (below == REGU) begin
                m_state = ST_RISE;
            end else if (below == BRAK) begin
                m_pulse[0] = 1; m_state = ST_RISE; m_col = ecol; m_row = erow;
            end else if (below == COIN) begin
                m_pulse[1] = 1; m_state = ST_RISE; m_col = ecol; m_row = erow;
            end else if (below == GATE) begin
                m_pulse[3] = 1; m_state = ST_DONE; m_col = ecol; m_row = erow;
            end else if (below == PORT) begin
                m_pulse[2] = 1; m_state = ST_RISE; m_col = ecol; m_row = erow;
                m_x = int'(tc[7:4]) * 64;
                m_y = (tc[3:0] == 4'd0) ? 0 : (int'(tc[3:0]) - 1) * 64;
            end
        end
        if (steer) begin
            if (lk && !rk) begin
                if (!(m_x % 64 == 0 && (!passable(int'(area[0])) || m_x == 0))) m_x -= HS;
            end else if (rk && !lk) begin
                if (!(m_x % 64 == 0 && (!passable(int'(area[2])) || m_x == (COLS - 1) * 64))) m_x += HS;
            end
        end
    endtask

    task automatic frame();
        @(negedge clk);
        sof = 1'b1;
        @(posedge clk);
        #1;
        sof = 1'b0;
        model_frame();
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
        m_pulse = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        lk = 1'b0; rk = 1'b0; area = '0; tc = '0;
        model_reset();
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        m_state = ST_IDLE; m_x = SX; m_y = SY; m_cnt = 0; m_pulse = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d need 0", state); end
        n_cmp++; if (bumpy_x !== 11'd0 || bumpy_y !== 11'd64) begin n_err++; $display("FAIL reset_pos: got %0d,%0d need 0,64", bumpy_x, bumpy_y); end
        n_cmp++; if (dut_pulses() !== 5'd0 || event_col !== 4'd0 || event_row !== 3'd0) begin n_err++; $display("FAIL reset_events: pulses %b col %0d row %0d need 0", dut_pulses(), event_col, event_row); end
        $display("test_reset: state=%0d x=%0d y=%0d", state, bumpy_x, bumpy_y);
    endtask

    task automatic test_brick();
        do_reset();
        area[3] = 3'(BRAK);
        frame();
        n_cmp++; if (state !== 3'd2 || dut_pulses() !== 5'd0) begin n_err++; $display("FAIL brick_first_sof: state %0d pulses %b need 2, 0", state, dut_pulses()); end
        frame();
        n_cmp++; if (brick_hit !== 1'b1 || state !== 3'd1) begin n_err++; $display("FAIL brick_hit: hit %b state %0d need 1, 1", brick_hit, state); end
        n_cmp++; if (event_col !== 4'd0 || event_row !== 3'd2) begin n_err++; $display("FAIL brick_tile: col %0d row %0d need 0, 2", event_col, event_row); end
        idle_cycle();
        n_cmp++; if (brick_hit !== 1'b0) begin n_err++; $display("FAIL brick_one_clock: hit %b need 0", brick_hit); end
        for (int i = 0; i < BF; i++) frame();
        n_cmp++; if (bumpy_y !== 11'd32 || state !== 3'd2) begin n_err++; $display("FAIL brick_apex: y %0d state %0d need 32, 2", bumpy_y, state); end
        for (int i = 0; i < BF; i++) frame();
        n_cmp++; if (bumpy_y !== 11'd64 || state !== 3'd2) begin n_err++; $display("FAIL brick_return: y %0d state %0d need 64, 2", bumpy_y, state); end
        frame();
        n_cmp++; if (brick_hit !== 1'b1 || state !== 3'd1) begin n_err++; $display("FAIL brick_second_land: hit %b state %0d need 1, 1", brick_hit, state); end
        $display("test_brick: y=%0d state=%0d", bumpy_y, state);
    endtask

    task automatic test_spike();
        do_reset();
        area[2] = 3'(FREE);
        area[3] = 3'(SPIK);
        frame();
        frame();
        n_cmp++; if (death !== 1'b1 || state !== 3'd3) begin n_err++; $display("FAIL spike_death: death %b state %0d need 1, 3", death, state); end
        idle_cycle();
        n_cmp++; if (death !== 1'b0) begin n_err++; $display("FAIL spike_one_clock: death %b need 0", death); end
        rk = 1'b1;
        for (int i = 0; i < 10; i++) frame();
        rk = 1'b0;
        n_cmp++; if (bumpy_x !== 11'd0 || bumpy_y !== 11'd64 || state !== 3'd3) begin n_err++; $display("FAIL dead_frozen: x %0d y %0d state %0d need 0, 64, 3", bumpy_x, bumpy_y, state); end
        do_restart();
        n_cmp++; if (bumpy_x !== 11'd0 || bumpy_y !== 11'd64 || state !== 3'd0) begin n_err++; $display("FAIL restart: x %0d y %0d state %0d need 0, 64, 0", bumpy_x, bumpy_y, state); end
        $display("test_spike: state=%0d", state);
    endtask

    task automatic test_steering();
        do_reset();
        area[3] = 3'(REGU);
        frame();
        frame();
        rk = 1'b1;
        area[2] = 3'(REGU);
        frame();
        n_cmp++; if (bumpy_x !== 11'd0 || state !== 3'd1) begin n_err++; $display("FAIL steer_blocked: x %0d state %0d need 0, 1", bumpy_x, state); end
        area[2] = 3'(FREE);
        frame();
        n_cmp++; if (bumpy_x !== 11'd4) begin n_err++; $display("FAIL steer_right: x %0d need 4", bumpy_x); end
        lk = 1'b1;
        frame();
        n_cmp++; if (bumpy_x !== 11'd4) begin n_err++; $display("FAIL steer_both: x %0d need 4", bumpy_x); end
        lk = 1'b0; rk = 1'b0;
        $display("test_steering: x=%0d", bumpy_x);
    endtask

    task automatic test_teleport();
        do_reset();
        area[3] = 3'(PORT);
        tc = 8'b0111_0110;
        frame();
        frame();
        n_cmp++; if (teleport !== 1'b1 || state !== 3'd1) begin n_err++; $display("FAIL teleport_pulse: pulse %b state %0d need 1, 1", teleport, state); end
        n_cmp++; if (bumpy_x !== 11'd448 || bumpy_y !== 11'd320) begin n_err++; $display("FAIL teleport_pos: x %0d y %0d need 448, 320", bumpy_x, bumpy_y); end
        $display("test_teleport: x=%0d y=%0d", bumpy_x, bumpy_y);
    endtask

    task automatic test_fall_off();
        do_reset();
        frame();
        for (int i = 0; i < (384 - 64) / VS; i++) frame();
        n_cmp++; if (bumpy_y !== 11'd384 || state !== 3'd2) begin n_err++; $display("FAIL fall_bottom: y %0d state %0d need 384, 2", bumpy_y, state); end
        frame();
        n_cmp++; if (death !== 1'b1 || state !== 3'd3 || bumpy_y !== 11'd384) begin n_err++; $display("FAIL fall_off_death: death %b state %0d y %0d need 1, 3, 384", death, state, bumpy_y); end
        $display("test_fall_off: state=%0d y=%0d", state, bumpy_y);
    endtask

    task automatic test_reset_priority();
        do_reset();
        area[3] = 3'(REGU);
        frame();
        frame();
        rk = 1'b1;
        for (int i = 0; i < 3; i++) frame();
        n_cmp++; if (bumpy_x !== 11'd12 || bumpy_y !== 11'd52) begin n_err++; $display("FAIL prio_setup: x %0d y %0d need 12, 52", bumpy_x, bumpy_y); end
        @(negedge clk);
        reset = 1'b1; sof = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; sof = 1'b0; rk = 1'b0;
        model_reset();
        n_cmp++; if (bumpy_x !== 11'd0 || bumpy_y !== 11'd64 || state !== 3'd0 || dut_pulses() !== 5'd0) begin n_err++; $display("FAIL reset_priority: x %0d y %0d state %0d pulses %b need 0, 64, 0, 0", bumpy_x, bumpy_y, state, dut_pulses()); end
        $display("test_reset_priority: state=%0d", state);
    endtask

    function automatic logic [2:0] rand_tile(input bit side);
        int r;
        r = $urandom_range(0, 15);
        if (side) return (r < 9) ? 3'(FREE) : 3'($urandom_range(0, 6));
        if (r < 5) return 3'(FREE);
        if (r < 8) return 3'(REGU);
        if (r < 10) return 3'(BRAK);
        if (r < 12) return 3'(COIN);
        if (r < 13) return 3'(PORT);
        if (r < 14) return 3'(GATE);
        return 3'(SPIK);
    endfunction

    task automatic test_random();
        logic [37:0] obs, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((m_state == ST_DEAD || m_state == ST_DONE) && $urandom_range(0, 3) == 0) begin
                do_restart();
            end else if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                area[0] = rand_tile(1'b1);
                area[1] = rand_tile(1'b1);
                area[2] = rand_tile(1'b1);
                area[3] = rand_tile(1'b0);
                tc = {4'($urandom_range(0, COLS - 1)), 4'($urandom_range(0, ROWS - 1))};
                lk = 1'($urandom_range(0, 1));
                rk = 1'($urandom_range(0, 1));
                frame();
            end
            obs = {state, bumpy_x, bumpy_y, dut_pulses(), event_col, event_row};
            exp = {3'(m_state), 11'(m_x), 11'(m_y), m_pulse, 4'(m_col), 3'(m_row)};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random_frame %0d: state/x/y/pulses/col/row got %0d/%0d/%0d/%b/%0d/%0d need %0d/%0d/%0d/%b/%0d/%0d",
                         i, state, bumpy_x, bumpy_y, dut_pulses(), event_col, event_row,
                         m_state, m_x, m_y, m_pulse, m_col, m_row);
                m_state = int'(state); m_x = int'(bumpy_x); m_y = int'(bumpy_y);
            end
            n_cmp++;
            if (bumpy_x > 11'((COLS - 1) * 64) || bumpy_y > 11'((ROWS - 1) * 64)) begin
                n_err++;
                $display("FAIL random_bounds %0d: x %0d y %0d", i, bumpy_x, bumpy_y);
            end
        end
        lk = 1'b0; rk = 1'b0;
        $display("test_random: 3000 steps, final x=%0d y=%0d state=%0d", bumpy_x, bumpy_y, state);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_brick();
        test_spike();
        test_steering();
        test_teleport();
        test_fall_off();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
